// File: rtl/alu_pkg.sv
// alu_pkg: shared width, opcodes, compare codes and class-flag struct for the ALU
package alu_pkg;
  localparam int WIDTH = 16;
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_NAND = 4'h6;
  localparam logic [3:0] OP_NOR  = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_XNOR = 4'h9;
  localparam logic [3:0] OP_EQ   = 4'hA;
  localparam logic [3:0] OP_GT   = 4'hB;
  localparam logic [3:0] OP_LT   = 4'hC;
  localparam logic [3:0] OP_SHR  = 4'hD;
  localparam logic [3:0] OP_SHL  = 4'hE;
  localparam logic [3:0] OP_NOP  = 4'hF;
  localparam int CMP_EQ = 1;
  localparam int CMP_GT = 2;
  localparam int CMP_LT = 3;
  typedef struct packed {
    logic arith;
    logic logic_op;
    logic cmp;
    logic shift;
  } alu_class_t;
endpackage

// File: rtl/alu_if.sv
// alu_if: operand/function inputs and registered result/flag outputs of the ALU
interface alu_if #(parameter int WIDTH = 16);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALU_FUN;
  logic [WIDTH-1:0] ALU_OUT;
  logic             Carry_Flag;
  logic             Arith_Flag;
  logic             Logic_Flag;
  logic             CMP_Flag;
  logic             Shift_Flag;
  modport master (output A, B, ALU_FUN,
                  input ALU_OUT, Carry_Flag, Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag);
  modport slave (input A, B, ALU_FUN,
                 output ALU_OUT, Carry_Flag, Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag);
endinterface

// File: rtl/alu_flag_dec.sv
// alu_flag_dec: combinational function code to operation-class decode (NOP yields no class)
module alu_flag_dec import alu_pkg::*; (
  input  logic [3:0] fun,
  output alu_class_t cls
);
  always_comb begin
    cls.arith    = fun <= OP_DIV;
    cls.logic_op = fun >= OP_AND && fun <= OP_XNOR;
    cls.cmp      = fun >= OP_EQ && fun <= OP_LT;
    cls.shift    = fun == OP_SHR || fun == OP_SHL;
  end
endmodule

// File: rtl/alu_core.sv
// alu_core: registered 16-bit ALU; define ALU_DIV_EN to build the unsigned divider
module alu_core import alu_pkg::*; #(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input logic CLK,
  input logic RST,
  alu_if.slave bus
);
  logic [WIDTH-1:0] res;
  logic             carry;
  alu_class_t       cls;
  alu_flag_dec u_dec (.fun(bus.ALU_FUN), .cls(cls));
  always_comb begin
    res   = '0;
    carry = 1'b0;
    case (bus.ALU_FUN)
      OP_ADD:  {carry, res} = {1'b0, bus.A} + {1'b0, bus.B};
      OP_SUB:  begin
        res   = bus.A - bus.B;
        carry = bus.A < bus.B;
      end
      OP_MUL:  res = bus.A * bus.B;
`ifdef ALU_DIV_EN
      OP_DIV:  res = (bus.B == '0) ? '1 : bus.A / bus.B;
`else
      OP_DIV:  res = '0;
`endif
      OP_AND:  res = bus.A & bus.B;
      OP_OR:   res = bus.A | bus.B;
      OP_NAND: res = ~(bus.A & bus.B);
      OP_NOR:  res = ~(bus.A | bus.B);
      OP_XOR:  res = bus.A ^ bus.B;
      OP_XNOR: res = ~(bus.A ^ bus.B);
      OP_EQ:   res = (bus.A == bus.B) ? WIDTH'(CMP_EQ) : '0;
      OP_GT:   res = (bus.A > bus.B) ? WIDTH'(CMP_GT) : '0;
      OP_LT:   res = (bus.A < bus.B) ? WIDTH'(CMP_LT) : '0;
      OP_SHR:  res = bus.A >> 1;
      OP_SHL:  res = bus.A << 1;
      default: res = '0;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      bus.ALU_OUT    <= '0;
      bus.Carry_Flag <= 1'b0;
      bus.Arith_Flag <= 1'b0;
      bus.Logic_Flag <= 1'b0;
      bus.CMP_Flag   <= 1'b0;
      bus.Shift_Flag <= 1'b0;
    end else begin
      bus.ALU_OUT    <= res;
      bus.Carry_Flag <= carry;
      bus.Arith_Flag <= cls.arith;
      bus.Logic_Flag <= cls.logic_op;
      bus.CMP_Flag   <= cls.cmp;
      bus.Shift_Flag <= cls.shift;
    end
  end
endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: table-driven directed check of alu_core plus reset/hold sequences
module tb_alu_core;
  import alu_pkg::*;
  typedef struct {
    logic [3:0]  fun;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] out;
    logic        c;
    logic [3:0]  cls;
  } vec_t;
  localparam logic [3:0] CA = 4'b1000, CL = 4'b0100, CC = 4'b0010, CS = 4'b0001, CN = 4'b0000;
`ifdef ALU_DIV_EN
  localparam logic [15:0] DIV_16_2 = 16'h0008, DIV_X_0 = 16'hFFFF, DIV_7_2 = 16'h0003;
`else
  localparam logic [15:0] DIV_16_2 = 16'h0000, DIV_X_0 = 16'h0000, DIV_7_2 = 16'h0000;
`endif
  logic CLK = 1'b0;
  logic RST;
  int n_cmp = 0;
  int n_bad = 0;
  vec_t vecs [31];
  alu_if #(.WIDTH(16)) bus ();
  alu_core #(.WIDTH(16)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  always #5 CLK = ~CLK;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic [3:0] fun, input logic [15:0] a, input logic [15:0] b);
    @(negedge CLK);
    bus.ALU_FUN = fun;
    bus.A = a;
    bus.B = b;
    @(posedge CLK);
    #1;
  endtask
  function automatic logic [4:0] flags();
    return {bus.Carry_Flag, bus.Arith_Flag, bus.Logic_Flag, bus.CMP_Flag, bus.Shift_Flag};
  endfunction
  initial begin
    vecs[0]  = '{OP_ADD,  16'h0011, 16'h0022, 16'h0033, 1'b0, CA};
    vecs[1]  = '{OP_ADD,  16'hFFFF, 16'h0001, 16'h0000, 1'b1, CA};
    vecs[2]  = '{OP_SUB,  16'h0022, 16'h0011, 16'h0011, 1'b0, CA};
    vecs[3]  = '{OP_SUB,  16'h0000, 16'h0001, 16'hFFFF, 1'b1, CA};
    vecs[4]  = '{OP_SUB,  16'h0027, 16'h0027, 16'h0000, 1'b0, CA};
    vecs[5]  = '{OP_MUL,  16'h0002, 16'h0003, 16'h0006, 1'b0, CA};
    vecs[6]  = '{OP_MUL,  16'h0101, 16'h0100, 16'h0100, 1'b0, CA};
    vecs[7]  = '{OP_DIV,  16'h0010, 16'h0002, DIV_16_2, 1'b0, CA};
    vecs[8]  = '{OP_DIV,  16'h1234, 16'h0000, DIV_X_0,  1'b0, CA};
    vecs[9]  = '{OP_DIV,  16'h0007, 16'h0002, DIV_7_2,  1'b0, CA};
    vecs[10] = '{OP_AND,  16'h00FF, 16'h0F0F, 16'h000F, 1'b0, CL};
    vecs[11] = '{OP_OR,   16'h00FF, 16'h0F0F, 16'h0FFF, 1'b0, CL};
    vecs[12] = '{OP_NAND, 16'h00FF, 16'h0F0F, 16'hFFF0, 1'b0, CL};
    vecs[13] = '{OP_NOR,  16'h00FF, 16'h0F0F, 16'hF000, 1'b0, CL};
    vecs[14] = '{OP_XOR,  16'h00FF, 16'h0F0F, 16'h0FF0, 1'b0, CL};
    vecs[15] = '{OP_XNOR, 16'h00FF, 16'h0F0F, 16'hF00F, 1'b0, CL};
    vecs[16] = '{OP_EQ,   16'h0027, 16'h0027, 16'h0001, 1'b0, CC};
    vecs[17] = '{OP_EQ,   16'h0027, 16'h0026, 16'h0000, 1'b0, CC};
    vecs[18] = '{OP_GT,   16'h0027, 16'h0013, 16'h0002, 1'b0, CC};
    vecs[19] = '{OP_GT,   16'h0010, 16'h0027, 16'h0000, 1'b0, CC};
    vecs[20] = '{OP_GT,   16'h8000, 16'h7FFF, 16'h0002, 1'b0, CC};
    vecs[21] = '{OP_LT,   16'h0010, 16'h0027, 16'h0003, 1'b0, CC};
    vecs[22] = '{OP_LT,   16'h0027, 16'h0027, 16'h0000, 1'b0, CC};
    vecs[23] = '{OP_SHR,  16'h0022, 16'hFFFF, 16'h0011, 1'b0, CS};
    vecs[24] = '{OP_SHR,  16'h8001, 16'h0000, 16'h4000, 1'b0, CS};
    vecs[25] = '{OP_SHL,  16'h0011, 16'hFFFF, 16'h0022, 1'b0, CS};
    vecs[26] = '{OP_SHL,  16'h8001, 16'h0000, 16'h0002, 1'b0, CS};
    vecs[27] = '{OP_ADD,  16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1, CA};
    vecs[28] = '{OP_NOP,  16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, CN};
    vecs[29] = '{OP_AND,  16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, CL};
    vecs[30] = '{OP_NOP,  16'h1234, 16'h0001, 16'h0000, 1'b0, CN};
    RST = 1'b1;
    drive(OP_ADD, 16'h0005, 16'h0005);
    check("reset_out", bus.ALU_OUT, 16'h0000);
    check("reset_flags", flags(), 5'b0);
    RST = 1'b0;
    for (int i = 0; i < 31; i++) begin
      drive(vecs[i].fun, vecs[i].a, vecs[i].b);
      check($sformatf("v%0d_out", i), bus.ALU_OUT, vecs[i].out);
      check($sformatf("v%0d_flags", i), flags(), {vecs[i].c, vecs[i].cls});
    end
    drive(OP_ADD, 16'h0005, 16'h0005);
    check("pre_reset_out", bus.ALU_OUT, 16'h000A);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check("reset_wins_out", bus.ALU_OUT, 16'h0000);
    check("reset_wins_flags", flags(), 5'b0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    check("post_reset_out", bus.ALU_OUT, 16'h000A);
    check("post_reset_flags", flags(), 5'b01000);
    drive(OP_SUB, 16'h0000, 16'h0002);
    @(negedge CLK);
    bus.ALU_FUN = OP_SHL;
    bus.A = 16'h0100;
    #4;
    check("hold_out", bus.ALU_OUT, 16'hFFFE);
    check("hold_flags", flags(), 5'b11000);
    @(posedge CLK);
    #1;
    check("after_hold_out", bus.ALU_OUT, 16'h0200);
    check("after_hold_flags", flags(), 5'b00001);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
